// File: rtl/sc_display_pkg.sv
// Shared constants, segment table and FSM state type for the sc_out_display decimal readout.
package sc_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Six displayed digits plus one extra digit that only exists to detect overflow
    localparam int BCD_DIGITS = 7;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Double-dabble correction step: every BCD digit >= 5 gets +3 ahead of the shift
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit BCD digit to active-low 7-segment pattern; non-decimal codes show blank.
module seg7_decoder
    import sc_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup with a blank fallback for codes 10..15
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_TABLE[0];
            4'd1:    seg = SEG_TABLE[1];
            4'd2:    seg = SEG_TABLE[2];
            4'd3:    seg = SEG_TABLE[3];
            4'd4:    seg = SEG_TABLE[4];
            4'd5:    seg = SEG_TABLE[5];
            4'd6:    seg = SEG_TABLE[6];
            4'd7:    seg = SEG_TABLE[7];
            4'd8:    seg = SEG_TABLE[8];
            4'd9:    seg = SEG_TABLE[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sc_out_display.sv
// Shows the CPU output port in decimal on six active-low 7-segment digits via a sequential
// double-dabble converter. Define SC_OUT_DISPLAY_LZB_EN to blank leading zero digits.
module sc_out_display
    import sc_display_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] value_in,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic [6:0]            hex4,
    output logic [6:0]            hex5,
    output logic                  busy,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]           bin_q, bin_d;
    logic [DATA_WIDTH-1:0]           last_q, last_d;
    logic [BCD_W-1:0]                bcd_q, bcd_d;
    logic                            loaded_q, loaded_d;
    logic                            busy_q, busy_d;
    logic                            ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0][6:0]      hex_q, hex_d;

    logic [BCD_W-1:0]                bcd_adj_s;
    logic [NUM_DIGITS-1:0][6:0]      dec_seg_s;
    logic [NUM_DIGITS-1:0][6:0]      disp_s;
    logic                            ovf_s;
`ifdef SC_OUT_DISPLAY_LZB_EN
    logic                            lead_s;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
            seg7_decoder u_dec (
                .digit (bcd_q[4*g +: 4]),
                .seg   (dec_seg_s[g])
            );
        end
    endgenerate

    // Final display image from the finished BCD value; only latched on the DONE edge
    always_comb begin
        disp_s = dec_seg_s;
        ovf_s  = (bcd_q[BCD_W-1 -: 4] != 4'd0);
`ifdef SC_OUT_DISPLAY_LZB_EN
        lead_s = 1'b1;
`endif
        if (ovf_s) begin
            disp_s = {NUM_DIGITS{SEG_DASH}};
        end else begin
`ifdef SC_OUT_DISPLAY_LZB_EN
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (lead_s && (bcd_q[4*i +: 4] == 4'd0)) begin
                    disp_s[i] = SEG_BLANK;
                end else begin
                    lead_s = 1'b0;
                end
            end
`else
            disp_s = dec_seg_s;
`endif
        end
    end

    // Conversion FSM: capture on change, shift DATA_WIDTH times, publish once
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        last_d    = last_q;
        bcd_d     = bcd_q;
        loaded_d  = loaded_q;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        hex_d     = hex_q;
        bcd_adj_s = bcd_add3(bcd_q);
        case (state_q)
            IDLE: begin
                if (!loaded_q || (value_in != last_q)) begin
                    bin_d   = value_in;
                    last_d  = value_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj_s, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                hex_d    = disp_s;
                ovf_d    = ovf_s;
                loaded_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset blanks the display and forces a fresh conversion
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bin_q    <= '0;
            last_q   <= '0;
            bcd_q    <= '0;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hex_q    <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            last_q   <= last_d;
            bcd_q    <= bcd_d;
            loaded_q <= loaded_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            hex_q    <= hex_d;
        end
    end

    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign hex4     = hex_q[4];
    assign hex5     = hex_q[5];
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sc_out_display.sv
// Scoreboard bench for sc_out_display: expected displays come from a decimal reference model.
module tb_sc_out_display;

    localparam int DW = 20;

    logic          clock = 1'b0;
    logic          resetn;
    logic [DW-1:0] value_in;
    logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5;
    logic          busy;
    logic          overflow;

    sc_out_display #(.DATA_WIDTH(DW), .NUM_DIGITS(6)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .value_in (value_in),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [41:0] hex;
        logic        ovf;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_busy = 1'b0;

    function automatic logic [6:0] seg_of(int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    // Reference: decimal digits by division, dashes above 999999
    function automatic exp_t model(int v, int issue, int lat);
        exp_t e;
        int   d [6];
        int   t;
        bit   lead;
        e.issue = issue;
        e.lat   = lat;
        e.ovf   = (v > 999999);
        t = v;
        for (int i = 0; i < 6; i++) begin
            d[i] = t % 10;
            t    = t / 10;
        end
        e.hex = '0;
        for (int i = 0; i < 6; i++) begin
            e.hex[i*7 +: 7] = e.ovf ? 7'h3F : seg_of(d[i]);
        end
`ifdef SC_OUT_DISPLAY_LZB_EN
        lead = 1'b1;
        if (!e.ovf) begin
            for (int i = 5; i >= 1; i--) begin
                if (lead && d[i] == 0) e.hex[i*7 +: 7] = 7'h7F;
                else lead = 1'b0;
            end
        end
`else
        lead = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic drive(int v);
        value_in = DW'(v);
        sb.push_back(model(v, cyc, 22));
    endtask

    task automatic wait_drain(int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries still pending after %0d cycles", sb.size(), bound);
            sb.delete();
        end
    endtask

    // Monitor: a falling busy outside reset marks a published result
    always @(negedge clock) begin
        if (!resetn) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_output: got hex %0h with nothing expected", {hex5, hex4, hex3, hex2, hex1, hex0});
                end else begin
                    mon_e = sb.pop_front();
                    check("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(mon_e.hex));
                    check("overflow", 64'(overflow), 64'(mon_e.ovf));
                    if (mon_e.lat > 0) check("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
                end
            end
            prev_busy = busy;
        end
    end

    int   last_v;
    int   v;
    int   iss;
    exp_t hold_e;

    initial begin
        resetn   = 1'b0;
        value_in = '0;
        tick(3);
        check("reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ovf", 64'(overflow), 64'(0));

        resetn = 1'b1;
        drive(0);
        wait_drain(60);

        drive(123456);  wait_drain(60);
        drive(999999);  wait_drain(60);
        drive(1000000); wait_drain(60);
        drive(7);       wait_drain(60);

        // input changes mid-conversion: 42 shown first, 58 follows one conversion later
        drive(42);
        iss = cyc;
        tick(5);
        value_in = DW'(58);
        sb.push_back(model(58, iss, 44));
        wait_drain(100);

        // reset in the middle of SHIFT
        value_in = DW'(314159);
        tick(11);
        resetn = 1'b0;
        #1;
        check("midrst_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_ovf", 64'(overflow), 64'(0));
        tick(2);
        resetn = 1'b1;
        sb.push_back(model(314159, cyc, 22));
        wait_drain(60);

        // toggle away and back before the conversion ends: exactly one result
        drive(271828);
        tick(3);
        value_in = DW'(5);
        tick(2);
        value_in = DW'(271828);
        wait_drain(60);

        hold_e = model(271828, 0, 0);
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("hold_busy", 64'(busy), 64'(0));
            check("hold_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(hold_e.hex));
        end

        last_v = 271828;
        for (int i = 0; i < 25; i++) begin
            if (i % 4 == 0) v = int'($urandom_range(0, 999));
            else            v = int'($urandom_range(0, (1 << DW) - 1));
            if (v == last_v) v = v ^ 1;
            drive(v);
            wait_drain(60);
            last_v = v;
        end

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
